// File: rtl/zeroriscy_fetch_fifo.sv
// Instruction prefetch queue: word fetches on req/gnt/rvalid, buffered in a shift FIFO.
// Optional same-cycle bypass of an empty queue: define ZERORISCY_FETCH_BYPASS_EN.
module zeroriscy_fetch_fifo #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q;
  logic [31:0]    fetch_addr_q;
  logic [31:0]    data_q [DEPTH];
  logic [31:0]    addr_q [DEPTH];

  logic           rx_s, byp_s, push_s, pop_s, issue_s, req_s;
  logic [CW:0]    count_after_s;
  logic [CW-1:0]  wr_idx_s;
  logic [31:0]    fetch_next_s, base_addr_s;

  // Accepted word: response to a live (non-aborted) request, not killed by a branch.
  assign rx_s = instr_rvalid_i & (state_q == WAIT_RVALID) & ~branch_i;
`ifdef ZERORISCY_FETCH_BYPASS_EN
  assign byp_s = rx_s & (count_q == '0);
`else
  assign byp_s = 1'b0;
`endif
  assign pop_s         = (count_q != '0) & ready_i;
  assign push_s        = rx_s & ~(byp_s & ready_i);
  assign count_after_s = {1'b0, count_q} + (CW+1)'(push_s) - (CW+1)'(pop_s);
  assign wr_idx_s      = count_q - CW'(pop_s);
  assign issue_s       = req_i & (count_after_s < DEPTH_C);
  assign fetch_next_s  = {fetch_addr_q[31:2] + 30'd1, 2'b00};

  // Request and next-state decode; a new request may follow a response in the same cycle.
  always_comb begin
    req_s   = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE:         req_s = branch_i | issue_s;
      WAIT_GNT:     req_s = 1'b1;
      WAIT_RVALID:  req_s = rx_s & issue_s;
      WAIT_ABORTED: req_s = instr_rvalid_i & issue_s;
      default:      req_s = 1'b0;
    endcase
    if (req_s & instr_gnt_i) begin
      state_d = WAIT_RVALID;
    end else if (req_s) begin
      state_d = WAIT_GNT;
    end else begin
      case (state_q)
        IDLE:         state_d = IDLE;
        WAIT_GNT:     state_d = WAIT_GNT;
        WAIT_RVALID:  state_d = branch_i ? (instr_rvalid_i ? WAIT_GNT : WAIT_ABORTED)
                                         : (instr_rvalid_i ? IDLE : WAIT_RVALID);
        WAIT_ABORTED: state_d = instr_rvalid_i ? IDLE : WAIT_ABORTED;
        default:      state_d = IDLE;
      endcase
    end
  end

  // Address presented to memory: branch target wins, then the post-response increment.
  always_comb begin
    if (branch_i) begin
      base_addr_s = addr_i;
    end else if (rx_s) begin
      base_addr_s = fetch_next_s;
    end else begin
      base_addr_s = fetch_addr_q;
    end
  end

  assign instr_req_o  = req_s;
  assign instr_addr_o = {base_addr_s[31:2], 2'b00};
  assign busy_o       = req_s | (state_q == WAIT_RVALID) | (state_q == WAIT_ABORTED);
  assign valid_o      = (count_q != '0) | byp_s;
  assign rdata_o      = byp_s ? instr_rdata_i : data_q[0];
  assign addr_o       = byp_s ? fetch_addr_q  : addr_q[0];

  // FSM state and fetch address; fetch_addr keeps a misaligned target until its word returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (branch_i) begin
        fetch_addr_q <= addr_i;
      end else if (rx_s) begin
        fetch_addr_q <= fetch_next_s;
      end else begin
        fetch_addr_q <= fetch_addr_q;
      end
    end
  end

  // Shift FIFO: entry 0 is always the head, so head outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
        addr_q[i] <= 32'h0000_0000;
      end
    end else if (branch_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_after_s[CW-1:0];
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (pop_s) begin
          data_q[i] <= data_q[i+1];
          addr_q[i] <= addr_q[i+1];
        end
      end
      if (push_s) begin
        data_q[wr_idx_s] <= instr_rdata_i;
        addr_q[wr_idx_s] <= fetch_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_fetch_fifo.sv
// Directed bench for zeroriscy_fetch_fifo (DEPTH=3): cycle table plus abort/reset sequences.
module tb_zeroriscy_fetch_fifo;

  logic        clk, rst_n, req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  int checks = 0;
  int fails  = 0;

`ifdef ZERORISCY_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  zeroriscy_fetch_fifo #(.DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic br; logic [31:0] a; logic rq, rdy, gnt, rv; logic [31:0] rd;
    logic ev; logic [31:0] erd, ead; logic ereq; logic [31:0] eia; logic ebusy; logic chkd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] a, input logic rq, input logic rdy,
                       input logic gnt, input logic rv, input logic [31:0] rd);
    branch_i = br; addr_i = a; req_i = rq; ready_i = rdy;
    instr_gnt_i = gnt; instr_rvalid_i = rv; instr_rdata_i = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // br  addr      rq rdy gnt rv rdata      ev   erdata  eaddr     ereq eiaddr    ebusy chkd
    vecs[0]  = '{1'b0, 32'h0,   1'b0,1'b0,1'b0,1'b0, 32'h0,  1'b0, 32'h0,  32'h0,   1'b0, 32'h0,   1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h80,  1'b1,1'b0,1'b1,1'b0, 32'h0,  1'b0, 32'h0,  32'h0,   1'b1, 32'h80,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b1,1'b0,1'b1,1'b1, 32'h13, BYP,  32'h13, 32'h80,  1'b1, 32'h84,  1'b1, BYP};
    vecs[3]  = '{1'b0, 32'h0,   1'b1,1'b0,1'b1,1'b1, 32'h17, 1'b1, 32'h13, 32'h80,  1'b1, 32'h88,  1'b1, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,   1'b1,1'b0,1'b1,1'b1, 32'h1B, 1'b1, 32'h13, 32'h80,  1'b0, 32'h8C,  1'b1, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,   1'b1,1'b0,1'b0,1'b0, 32'h0,  1'b1, 32'h13, 32'h80,  1'b0, 32'h8C,  1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,   1'b1,1'b1,1'b0,1'b0, 32'h0,  1'b1, 32'h13, 32'h80,  1'b1, 32'h8C,  1'b1, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,   1'b1,1'b1,1'b0,1'b0, 32'h0,  1'b1, 32'h17, 32'h84,  1'b1, 32'h8C,  1'b1, 1'b1};
    vecs[8]  = '{1'b1, 32'h40,  1'b1,1'b0,1'b0,1'b0, 32'h0,  1'b1, 32'h1B, 32'h88,  1'b1, 32'h40,  1'b1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,   1'b1,1'b0,1'b0,1'b0, 32'h0,  1'b0, 32'h0,  32'h0,   1'b1, 32'h40,  1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h102, 1'b1,1'b0,1'b1,1'b0, 32'h0,  1'b0, 32'h0,  32'h0,   1'b1, 32'h100, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0,   1'b1,1'b0,1'b0,1'b1, 32'hA1, BYP,  32'hA1, 32'h102, 1'b1, 32'h104, 1'b1, BYP};
    vecs[12] = '{1'b0, 32'h0,   1'b1,1'b1,1'b1,1'b0, 32'h0,  1'b1, 32'hA1, 32'h102, 1'b1, 32'h104, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 32'h0,   1'b0,1'b0,1'b0,1'b1, 32'hA2, BYP,  32'hA2, 32'h104, 1'b0, 32'h108, 1'b1, BYP};
    vecs[14] = '{1'b0, 32'h0,   1'b0,1'b0,1'b0,1'b0, 32'h0,  1'b1, 32'hA2, 32'h104, 1'b0, 32'h108, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Boot, backpressure, branch in WAIT_GNT and misaligned target, cycle by cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].br, vecs[i].a, vecs[i].rq, vecs[i].rdy, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("row%0d valid_o", i), {31'h0, valid_o}, {31'h0, vecs[i].ev});
      chk($sformatf("row%0d instr_req_o", i), {31'h0, instr_req_o}, {31'h0, vecs[i].ereq});
      chk($sformatf("row%0d instr_addr_o", i), instr_addr_o, vecs[i].eia);
      chk($sformatf("row%0d busy_o", i), {31'h0, busy_o}, {31'h0, vecs[i].ebusy});
      if (vecs[i].chkd) begin
        chk($sformatf("row%0d rdata_o", i), rdata_o, vecs[i].erd);
        chk($sformatf("row%0d addr_o", i), addr_o, vecs[i].ead);
      end
      next_cycle();
    end

    // Abort: branch while waiting for data; the in-flight word must be dropped.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort issue req", {31'h0, instr_req_o}, 32'h1);
    chk("abort issue addr", instr_addr_o, 32'h108);
    next_cycle();
    drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort branch req", {31'h0, instr_req_o}, 32'h0);
    chk("abort branch busy", {31'h0, busy_o}, 32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk("abort drop valid", {31'h0, valid_o}, 32'h0);
    chk("abort restart req", {31'h0, instr_req_o}, 32'h1);
    chk("abort restart addr", instr_addr_o, 32'h200);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort after valid", {31'h0, valid_o}, 32'h0);
    chk("abort gnt addr", instr_addr_o, 32'h200);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55);
    @(negedge clk);
    chk("abort next addr", instr_addr_o, 32'h204);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort head valid", {31'h0, valid_o}, 32'h1);
    chk("abort head rdata", rdata_o, 32'h55);
    chk("abort head addr", addr_o, 32'h200);
    next_cycle();

    // Reset while a response is outstanding; a late rvalid must be ignored.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst valid_o", {31'h0, valid_o}, 32'h0);
    chk("rst instr_req_o", {31'h0, instr_req_o}, 32'h0);
    chk("rst busy_o", {31'h0, busy_o}, 32'h0);
    chk("rst rdata_o", rdata_o, 32'h0);
    chk("rst addr_o", addr_o, 32'h0);
    chk("rst instr_addr_o", instr_addr_o, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
    @(negedge clk);
    chk("late rvalid busy", {31'h0, busy_o}, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("late rvalid valid_o", {31'h0, valid_o}, 32'h0);
    chk("late rvalid fetch addr", instr_addr_o, 32'h0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
